// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, lane count,
// error-flag values and the alignment/range check used by the responder.
package dm_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  localparam int  NUM_LANES  = 4;
  localparam logic ERR_NONE   = 1'b0;
  localparam logic ERR_ACCESS = 1'b1;

  // A word access is bad when the byte address is not word aligned or the
  // word index lies beyond the stored depth.
  function automatic logic access_err(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return ((addr[1:0] != 2'b00) || (word_idx >= depth)) ? ERR_ACCESS : ERR_NONE;
  endfunction

endpackage

// File: rtl/dm_responder_array.sv
// Word storage for the responder: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module dm_array
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clock,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we && be[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dm_responder.sv
// Target side of the CPU load/store port: accepts one word request, waits
// WAIT_CYCLES, commits the access and holds the response until it is taken.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both 1; the initiator holds its request stable until then, and the
  // responder holds resp_rdata/resp_err stable while resp_valid is 1.

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lat_write_q, lat_write_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [3:0]  lat_be_q, lat_be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        commit;
  logic        mem_we;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic [31:0] arr_rdata;

  // With no wait states the access commits on the accept edge, before the
  // latch holds the request, so the live request fields are used in IDLE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_write = lat_write_q;
      acc_addr  = lat_addr_q;
      acc_wdata = lat_wdata_q;
      acc_be    = lat_be_q;
    end
    acc_err = access_err(acc_addr, DEPTH_WORDS);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_write_d = lat_write_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    commit      = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lat_write_d = req_write;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          lat_be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'd0;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? 32'd0 : arr_rdata;
      mem_we  = acc_write && !acc_err;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 32'd0;
      lat_be_q    <= 4'd0;
      rdata_q     <= 32'd0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Reset outranks a commit landing on the same edge.
  dm_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clock (clock),
    .we    (mem_we && !reset),
    .be    (acc_be),
    .idx   (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with two wait states, one with none;
// expected responses come from a small memory model through a scoreboard queue.
module tb_dm_responder;

  localparam int W = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Instance with W wait states.
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  dbg_state;

  // Instance with zero wait states.
  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_resp_valid, z_resp_ready, z_resp_err;
  logic [31:0] z_resp_rdata;
  logic [1:0]  z_dbg_state;

  dm_responder #(.DEPTH_WORDS(1024), .AW(10), .WAIT_CYCLES(W)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  dm_responder #(.DEPTH_WORDS(1024), .AW(10), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .dbg_state(z_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];          // {err, rdata}
  logic [31:0] mdl [int];         // reference memory, indexed by word

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
  endfunction

  // Drives one request on the W-wait instance, checks latency, optional
  // back-pressure stability, the scoreboard result and the return to idle.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int stall, input string tag);
    logic        e;
    logic [31:0] rd;
    logic [31:0] word;
    logic [32:0] first;
    logic [32:0] exp;
    int          acc_cyc;
    bit          seen;
    @(negedge clock);
    check({tag, ".req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    e  = model_err(a);
    rd = 32'd0;
    if (!e && !w) rd = mdl[int'(a[11:2])];
    if (!e && w) begin
      word = mdl.exists(int'(a[11:2])) ? mdl[int'(a[11:2])] : 32'd0;
      for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = d[8*i +: 8];
      mdl[int'(a[11:2])] = word;
    end
    exp_q.push_back({e, rd});
    @(posedge clock);
    #1 acc_cyc = cyc;
    @(negedge clock);
    req_valid = 1'b0;
    check({tag, ".req_ready_busy"}, req_ready, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    check({tag, ".resp_seen"}, seen, 1);
    check({tag, ".latency"}, cyc - acc_cyc, W);
    first = {resp_err, resp_rdata};
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      check({tag, ".hold_resp"}, {resp_valid, resp_err, resp_rdata}, {1'b1, first});
      check({tag, ".hold_ready"}, req_ready, 0);
    end
    exp = exp_q.pop_front();
    check({tag, ".resp"}, {resp_err, resp_rdata}, exp);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check({tag, ".cleared"}, {resp_valid, resp_err, resp_rdata, req_ready}, {1'b0, 1'b0, 32'd0, 1'b1});
  endtask

  initial begin
    bit rose;
    reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0; resp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_req_be = 0; z_resp_ready = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("reset.outputs", {req_ready, resp_valid, resp_err, resp_rdata, dbg_state},
          {1'b1, 1'b0, 1'b0, 32'd0, 2'd0});

    // Full store, then load back with back-pressure
    txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st_full");
    txn(0, 32'h10, 32'h0, 4'h0, 4, "ld_full");

    // Byte-merge store and readback
    txn(1, 32'h10, 32'h11223344, 4'b0101, 0, "st_merge");
    txn(0, 32'h10, 32'h0, 4'hF, 0, "ld_merge");

    // be = 0 store is a harmless no-op
    txn(1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, "st_be0");
    txn(0, 32'h10, 32'h0, 4'h0, 1, "ld_be0");

    // Misaligned and out-of-range accesses
    txn(1, 32'h0, 32'h0BADC0DE, 4'hF, 0, "st_word0");
    txn(0, 32'h13, 32'h0, 4'h0, 0, "ld_misalign");
    txn(0, 32'h1000, 32'h0, 4'h0, 0, "ld_range");
    txn(1, 32'h1000, 32'h55AA55AA, 4'hF, 0, "st_range");
    txn(0, 32'h0, 32'h0, 4'h0, 0, "ld_word0");
    txn(1, 32'h2, 32'h77777777, 4'hF, 0, "st_misalign");
    txn(0, 32'h0, 32'h0, 4'h0, 0, "ld_word0_again");
    txn(1, 32'hFFC, 32'h13572468, 4'hF, 0, "st_last");
    txn(0, 32'hFFC, 32'h0, 4'h0, 0, "ld_last");

    // Reset during WAIT discards the store
    txn(1, 32'h20, 32'h12345678, 4'hF, 0, "st_prior");
    @(negedge clock);
    req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clock);
    @(negedge clock);
    req_valid = 0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_wait.idle", {req_ready, resp_valid, dbg_state}, {1'b1, 1'b0, 2'd0});
    rose = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (resp_valid) rose = 1'b1;
    end
    check("rst_wait.no_resp", rose, 0);
    txn(0, 32'h20, 32'h0, 4'h0, 0, "ld_after_rst");

    // Zero wait states: request held high, responses taken immediately
    @(negedge clock);
    z_req_valid = 1; z_req_write = 1; z_req_addr = 32'h44; z_req_wdata = 32'hA5A5A5A5; z_req_be = 4'hF;
    for (int k = 0; k < 6; k++) begin
      check("z.ready_pattern", z_req_ready, (k % 2) == 0);
      check("z.valid_pattern", z_resp_valid, (k % 2) == 1);
      @(negedge clock);
    end
    z_req_valid = 0;
    @(negedge clock);
    check("z.idle", {z_req_ready, z_resp_valid}, {1'b1, 1'b0});
    z_req_valid = 1; z_req_write = 0; z_req_addr = 32'h44;
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    @(negedge clock);
    z_req_valid = 0;
    check("z.ld_valid", z_resp_valid, 1);
    check("z.ld_resp", {z_resp_err, z_resp_rdata}, exp_q.pop_front());
    @(negedge clock);
    z_req_valid = 1; z_req_write = 0; z_req_addr = 32'h45;
    exp_q.push_back({1'b1, 32'h0});
    @(negedge clock);
    z_req_valid = 0;
    check("z.err_valid", z_resp_valid, 1);
    check("z.err_resp", {z_resp_err, z_resp_rdata}, exp_q.pop_front());
    @(negedge clock);

    check("scoreboard.empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
